// File: rtl/ctrl_pipe_pkg.sv
// ctrl_pipe_pkg: shared types and constants for the control pipeline.
//   ctrl_bundle_t : packed decode control bundle (5 bits)
//   CTRL_NOP      : all-zero bundle loaded on bubble/flush/reset
//   DEPTH_MAX     : largest supported pipeline depth
package ctrl_pipe_pkg;

  localparam int unsigned DEPTH_MAX = 8;

  typedef struct packed {
    logic       reg_wen;
    logic       mem_r;
    logic       mem_w;
    logic [1:0] wb_sel;
  } ctrl_bundle_t;

  localparam int unsigned CTRL_W = $bits(ctrl_bundle_t);

  localparam ctrl_bundle_t CTRL_NOP = '0;

endpackage

// File: rtl/ctrl_pipe_stage.sv
// ctrl_pipe_stage: one register slice of the control pipeline.
//   clk, reset_n          : clock, async active-low reset
//   flush                 : clear this stage (wins over hold)
//   hold                  : retain current contents
//   bubble                : upstream is holding or being flushed, load empty
//   prev_valid, prev_ctrl : contents offered by the upstream stage / decode
//   valid, ctrl           : registered stage contents
module ctrl_pipe_stage
  import ctrl_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = CTRL_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             hold,
  input  logic             bubble,
  input  logic             prev_valid,
  input  logic [WIDTH-1:0] prev_ctrl,
  output logic             valid,
  output logic [WIDTH-1:0] ctrl
);

  localparam logic [WIDTH-1:0] NOP = WIDTH'(CTRL_NOP);

  logic             valid_d;
  logic [WIDTH-1:0] ctrl_d;
  logic             take;

  // Next-state mux: flush > hold > advance; an empty advance always loads NOP
  always_comb begin
    valid_d = valid;
    ctrl_d  = ctrl;
    take    = prev_valid & ~bubble;
    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = NOP;
    end else if (!hold) begin
      valid_d = take;
      ctrl_d  = take ? prev_ctrl : NOP;
    end
  end

  // Stage registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      ctrl  <= NOP;
    end else begin
      valid <= valid_d;
      ctrl  <= ctrl_d;
    end
  end

endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: DEPTH-stage control-bundle pipeline with per-stage stall/flush.
//   clk, reset_n     : clock, async active-low reset
//   in_ctrl/in_valid : bundle from decode, captured into stage 0
//   stall, flush     : per-stage hold request / kill
//   stage_ctrl/valid : registered contents of every stage
//   stage_hold       : combinational per-stage hold (stall chained upstream)
//   in_ready         : stage 0 will accept this cycle
// Optional macro CTRL_PIPE_DBG_EN adds dbg_halt, dbg_step (inputs) and
// dbg_frozen, dbg_hold_cnt (registered outputs) for debug freeze/step.
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = CTRL_W,
  parameter int unsigned DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [WIDTH-1:0]            in_ctrl,
  input  logic                        in_valid,
  input  logic [DEPTH-1:0]            stall,
  input  logic [DEPTH-1:0]            flush,
`ifdef CTRL_PIPE_DBG_EN
  input  logic                        dbg_halt,
  input  logic                        dbg_step,
  output logic                        dbg_frozen,
  output logic [15:0]                 dbg_hold_cnt,
`endif
  output logic [DEPTH-1:0][WIDTH-1:0] stage_ctrl,
  output logic [DEPTH-1:0]            stage_valid,
  output logic [DEPTH-1:0]            stage_hold,
  output logic                        in_ready
);

  if (DEPTH < 1 || DEPTH > DEPTH_MAX) begin : g_bad_depth
    $error("ctrl_pipe: DEPTH out of range");
  end

  logic [DEPTH-1:0] stall_eff;

`ifdef CTRL_PIPE_DBG_EN
  logic step_q;
  logic step_pulse;

  // A rising step edge while halted lets exactly one edge through
  assign step_pulse = dbg_halt & dbg_step & ~step_q;
  assign stall_eff  = stall | {DEPTH{dbg_halt & ~step_pulse}};

  // Debug status: step edge detector, frozen flag, saturating hold counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      step_q       <= 1'b0;
      dbg_frozen   <= 1'b0;
      dbg_hold_cnt <= 16'h0000;
    end else begin
      step_q     <= dbg_step;
      dbg_frozen <= dbg_halt;
      if (stage_hold[0] && (dbg_hold_cnt != 16'hFFFF)) begin
        dbg_hold_cnt <= dbg_hold_cnt + 16'h0001;
      end
    end
  end
`else
  assign stall_eff = stall;
`endif

  // Stall propagates upstream within the cycle: hold[i] = OR of stall[i..DEPTH-1]
  always_comb begin
    logic hold_acc;
    hold_acc   = 1'b0;
    stage_hold = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      hold_acc      = hold_acc | stall_eff[i];
      stage_hold[i] = hold_acc;
    end
  end

  assign in_ready = ~stage_hold[0];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    if (gi == 0) begin : g_head
      ctrl_pipe_stage #(.WIDTH(WIDTH)) u_stage (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (flush[0]),
        .hold       (stage_hold[0]),
        .bubble     (1'b0),
        .prev_valid (in_valid),
        .prev_ctrl  (in_ctrl),
        .valid      (stage_valid[0]),
        .ctrl       (stage_ctrl[0])
      );
    end else begin : g_body
      // Upstream that holds or is flushed this edge hands down a bubble
      ctrl_pipe_stage #(.WIDTH(WIDTH)) u_stage (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (flush[gi]),
        .hold       (stage_hold[gi]),
        .bubble     (stage_hold[gi-1] | flush[gi-1]),
        .prev_valid (stage_valid[gi-1]),
        .prev_ctrl  (stage_ctrl[gi-1]),
        .valid      (stage_valid[gi]),
        .ctrl       (stage_ctrl[gi])
      );
    end
  end

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed self-checking bench for ctrl_pipe (DEPTH=2, WIDTH=5).
module tb_ctrl_pipe;

  logic            clk;
  logic            reset_n;
  logic [4:0]      in_ctrl;
  logic            in_valid;
  logic [1:0]      stall;
  logic [1:0]      flush;
  logic [1:0][4:0] stage_ctrl;
  logic [1:0]      stage_valid;
  logic [1:0]      stage_hold;
  logic            in_ready;

  int checks;
  int failures;

  ctrl_pipe #(.WIDTH(5), .DEPTH(2)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_ctrl     (in_ctrl),
    .in_valid    (in_valid),
    .stall       (stall),
    .flush       (flush),
    .stage_ctrl  (stage_ctrl),
    .stage_valid (stage_valid),
    .stage_hold  (stage_hold),
    .in_ready    (in_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compare whole pipe: valid bits {s1,s0} and ctrl {s1,s0}
  task automatic expect_pipe(input string tag, input logic [1:0] v, input logic [4:0] c1, input logic [4:0] c0);
    check_eq({tag, ".valid"}, 32'(stage_valid), 32'(v));
    check_eq({tag, ".ctrl"},  32'(stage_ctrl),  32'({c1, c0}));
  endtask

  // Advance one clock edge and settle 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] c, input logic [1:0] st, input logic [1:0] fl);
    in_valid = v;
    in_ctrl  = c;
    stall    = st;
    flush    = fl;
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    drive(1'b1, 5'b11111, 2'b10, 2'b00);

    // Reset state; hold/ready follow stall even in reset
    #2;
    expect_pipe("reset", 2'b00, 5'b0, 5'b0);
    check_eq("reset.hold", 32'(stage_hold), 32'(2'b11));
    check_eq("reset.ready", 32'(in_ready), 32'(1'b0));
    drive(1'b0, 5'b0, 2'b00, 2'b00);
    check_eq("idle.ready", 32'(in_ready), 32'(1'b1));
    #8;
    reset_n = 1'b1;

    // Two-edge latency of a single bundle; in_valid=0 ignores in_ctrl
    drive(1'b1, 5'b10110, 2'b00, 2'b00);
    step();
    expect_pipe("lat.e1", 2'b01, 5'b0, 5'b10110);
    drive(1'b0, 5'b11111, 2'b00, 2'b00);
    step();
    expect_pipe("lat.e2", 2'b10, 5'b10110, 5'b0);

    // Fill both stages, then stall[1] for 3 cycles
    drive(1'b1, 5'b00011, 2'b00, 2'b00);
    step();
    drive(1'b1, 5'b00101, 2'b00, 2'b00);
    step();
    expect_pipe("fill", 2'b11, 5'b00011, 5'b00101);
    drive(1'b1, 5'b01110, 2'b10, 2'b00);
    check_eq("st1.hold", 32'(stage_hold), 32'(2'b11));
    for (int k = 0; k < 3; k++) begin
      check_eq("st1.ready", 32'(in_ready), 32'(1'b0));
      step();
      expect_pipe("st1.held", 2'b11, 5'b00011, 5'b00101);
    end
    drive(1'b1, 5'b01110, 2'b00, 2'b00);
    check_eq("st1.resume_ready", 32'(in_ready), 32'(1'b1));
    step();
    expect_pipe("st1.resume", 2'b11, 5'b00101, 5'b01110);

    // stall[0] only: stage 0 holds, stage 1 takes a bubble
    drive(1'b1, 5'b01001, 2'b00, 2'b00);
    step();
    expect_pipe("st0.load", 2'b11, 5'b01110, 5'b01001);
    drive(1'b1, 5'b10000, 2'b01, 2'b00);
    check_eq("st0.hold", 32'(stage_hold), 32'(2'b01));
    check_eq("st0.ready", 32'(in_ready), 32'(1'b0));
    step();
    expect_pipe("st0.bubble", 2'b01, 5'b0, 5'b01001);

    // flush[0] with stall[0]: flush wins, stage 1 bubbles
    drive(1'b1, 5'b11111, 2'b00, 2'b00);
    step();
    expect_pipe("fs0.load", 2'b11, 5'b01001, 5'b11111);
    drive(1'b1, 5'b00110, 2'b01, 2'b01);
    check_eq("fs0.ready", 32'(in_ready), 32'(1'b0));
    step();
    expect_pipe("fs0.after", 2'b00, 5'b0, 5'b0);

    // flush[1] alone leaves stage 0 advancing normally
    drive(1'b1, 5'b00001, 2'b00, 2'b00);
    step();
    drive(1'b1, 5'b00010, 2'b00, 2'b00);
    step();
    expect_pipe("f1.fill", 2'b11, 5'b00001, 5'b00010);
    drive(1'b1, 5'b00100, 2'b00, 2'b10);
    step();
    expect_pipe("f1.after", 2'b01, 5'b0, 5'b00100);

    // flush both with stall[1]: both cleared, upstream still sees hold
    drive(1'b1, 5'b01100, 2'b00, 2'b00);
    step();
    drive(1'b1, 5'b11000, 2'b10, 2'b11);
    check_eq("f11.hold", 32'(stage_hold), 32'(2'b11));
    step();
    expect_pipe("f11.after", 2'b00, 5'b0, 5'b0);

    // Asynchronous reset between edges with both stages full
    drive(1'b1, 5'b00111, 2'b00, 2'b00);
    step();
    drive(1'b1, 5'b01000, 2'b00, 2'b00);
    step();
    expect_pipe("ar.full", 2'b11, 5'b00111, 5'b01000);
    drive(1'b1, 5'b01010, 2'b00, 2'b00);
    #1;
    reset_n = 1'b0;
    #1;
    expect_pipe("ar.low", 2'b00, 5'b0, 5'b0);
    #1;
    reset_n = 1'b1;
    #1;
    expect_pipe("ar.release", 2'b00, 5'b0, 5'b0);
    step();
    expect_pipe("ar.first", 2'b01, 5'b0, 5'b01010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
